// File: rtl/conv_scheduler.sv
// conv_scheduler: frame sequencer for Sobel edge detection.
// For each output position it requests a window, runs the MAC engine with the
// Gx and then the Gy kernel, combines the results into a saturated magnitude
// and edge flag, and writes the pixel to the result RAM in raster order.
module conv_scheduler #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 48,
  parameter int KSIZE   = 5,
  parameter int RES_W   = 16,
  parameter int THRESH  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             win_req,
  output logic [15:0]      win_x,
  output logic [15:0]      win_y,
  input  logic             win_valid,
  output logic             kernel_sel,
  output logic             eng_en,
  input  logic             eng_done,
  input  logic [RES_W-1:0] eng_result,
  output logic             pix_we,
  output logic [15:0]      pix_addr,
  output logic [7:0]       pix_data,
  output logic             pix_edge,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int OUT_W = IMG_W - KSIZE + 1;
  localparam int OUT_H = IMG_H - KSIZE + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_REQ      = 4'd1;
  localparam logic [3:0] S_WAIT_WIN = 4'd2;
  localparam logic [3:0] S_RUN_X    = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_RUN_Y    = 4'd5;
  localparam logic [3:0] S_COMB     = 4'd6;
  localparam logic [3:0] S_WRITE    = 4'd7;
  localparam logic [3:0] S_NEXT     = 4'd8;
  localparam logic [3:0] S_FIN      = 4'd9;

  logic [3:0]       state;
  logic [15:0]      x, y, addr;
  logic [RES_W-1:0] gx, gy;
  logic [RES_W:0]   mag;
  logic [TW-1:0]    tcnt;
  logic             error_r;
  logic             to_hit;
  logic [7:0]       sat;

  // |v| widened by one bit so the most negative value does not overflow
  function automatic logic [RES_W:0] abs_ext(input logic [RES_W-1:0] v);
    logic [RES_W:0] e;
    e = {v[RES_W-1], v};
    return v[RES_W-1] ? (~e + 1'b1) : e;
  endfunction

  assign to_hit = (tcnt == TW'(TIMEOUT - 1));

  // Frame sequencer, raster position, latched engine results and timeout watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      addr    <= '0;
      gx      <= '0;
      gy      <= '0;
      mag     <= '0;
      tcnt    <= '0;
      error_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_REQ;
          x       <= '0;
          y       <= '0;
          addr    <= '0;
          error_r <= 1'b0;
        end
        S_REQ: begin
          state <= S_WAIT_WIN;
          tcnt  <= '0;
        end
        // eng_done is not looked at here, so a coincident one is dropped
        S_WAIT_WIN: begin
          if (win_valid) begin
            state <= S_RUN_X;
            tcnt  <= '0;
          end else if (to_hit) begin
            state   <= S_FIN;
            error_r <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        S_RUN_X: begin
          if (eng_done) begin
            gx    <= eng_result;
            state <= S_GAP;
          end else if (to_hit) begin
            state   <= S_FIN;
            error_r <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        // one cycle with eng_en low lets the engine clear its accumulator
        S_GAP: begin
          state <= S_RUN_Y;
          tcnt  <= '0;
        end
        S_RUN_Y: begin
          if (eng_done) begin
            gy    <= eng_result;
            state <= S_COMB;
          end else if (to_hit) begin
            state   <= S_FIN;
            error_r <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        end
        S_COMB: begin
          mag   <= abs_ext(gx) + abs_ext(gy);
          state <= S_WRITE;
        end
        S_WRITE: state <= S_NEXT;
        S_NEXT: begin
          addr <= addr + 1'b1;
          if (x == 16'(OUT_W - 1)) begin
            x <= '0;
            if (y == 16'(OUT_H - 1)) state <= S_FIN;
            else begin
              y     <= y + 1'b1;
              state <= S_REQ;
            end
          end else begin
            x     <= x + 1'b1;
            state <= S_REQ;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sat = (|mag[RES_W:8]) ? 8'hFF : mag[7:0];

  // Moore outputs; pixel bus is zero except during the write strobe
  assign win_req    = (state == S_REQ);
  assign win_x      = x;
  assign win_y      = y;
  assign kernel_sel = (state == S_RUN_Y);
  assign eng_en     = (state == S_RUN_X) || (state == S_RUN_Y);
  assign pix_we     = (state == S_WRITE);
  assign pix_addr   = pix_we ? addr : 16'd0;
  assign pix_data   = pix_we ? sat : 8'd0;
  assign pix_edge   = pix_we && (int'(sat) >= THRESH);
  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign error      = error_r;

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: directed-plus-random bench for conv_scheduler on a 6x6
// frame (2x2 outputs), acting as window loader and MAC engine.
module tb_conv_scheduler;

  localparam int IMG_W = 6, IMG_H = 6, KSIZE = 5, RES_W = 16;
  localparam int THRESH = 128, TIMEOUT = 64;
  localparam int OUT_W = IMG_W - KSIZE + 1;
  localparam int OUT_H = IMG_H - KSIZE + 1;
  localparam int NPIX  = OUT_W * OUT_H;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             win_req, win_valid = 1'b0;
  logic [15:0]      win_x, win_y;
  logic             kernel_sel, eng_en;
  logic             eng_done = 1'b0;
  logic [RES_W-1:0] eng_result = '0;
  logic             pix_we, pix_edge, busy, done, error;
  logic [15:0]      pix_addr;
  logic [7:0]       pix_data;

  int vectors = 0, miscompares = 0;
  int we_cnt = 0, done_cnt = 0;

  conv_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .RES_W(RES_W),
                   .THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .win_req(win_req), .win_x(win_x), .win_y(win_y), .win_valid(win_valid),
    .kernel_sel(kernel_sel), .eng_en(eng_en), .eng_done(eng_done),
    .eng_result(eng_result), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_data(pix_data), .pix_edge(pix_edge), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // pulse counters observed mid-cycle
  always @(negedge clk) begin
    if (pix_we) we_cnt <= we_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {win_req, win_x, win_y, kernel_sel, eng_en, pix_we, pix_addr,
            pix_data, pix_edge, busy, done, error};
  endfunction

  // reference: min(|gx|+|gy|, 255) from plain integer arithmetic
  function automatic int ref_mag(input int gx, input int gy);
    int m;
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int rnd_res();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 200)) - 100;
    return int'($signed(16'($urandom)));
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
  endtask

  // one output position acting as loader and engine
  task automatic pixel(input int gx, input int gy, input int idx);
    int n, d, m;
    n = 0;
    while (!win_req && n < 10) begin tick(); n++; end
    chk("win_req_seen", win_req, 1);
    chk("win_x", win_x, 64'(idx % OUT_W));
    chk("win_y", win_y, 64'(idx / OUT_W));
    tick();
    chk("win_req_pulse", win_req, 0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      eng_done = 1'($urandom_range(0, 1));     // spurious, must be ignored
      eng_result = 16'($urandom);
      tick();
      chk("eng_en_wait_win", eng_en, 0);
    end
    win_valid = 1'b1;
    eng_done = 1'($urandom_range(0, 1));       // coincident with win_valid
    eng_result = 16'($urandom);
    tick();
    win_valid = 1'b0;
    eng_done = 1'b0;
    chk("run_x_en", eng_en, 1);
    chk("run_x_ksel", kernel_sel, 0);
    repeat ($urandom_range(0, 3)) begin tick(); chk("run_x_hold", eng_en, 1); end
    eng_done = 1'b1;
    eng_result = 16'(gx);
    tick();
    eng_done = 1'b0;
    eng_result = 16'($urandom);
    chk("gap_en_low", eng_en, 0);
    tick();
    chk("run_y_en", eng_en, 1);
    chk("run_y_ksel", kernel_sel, 1);
    repeat ($urandom_range(0, 3)) begin tick(); chk("run_y_hold", eng_en, 1); end
    eng_done = 1'b1;
    eng_result = 16'(gy);
    tick();
    eng_done = 1'b0;
    eng_result = 16'($urandom);
    n = 0;
    while (!pix_we && n < 5) begin tick(); n++; end
    m = ref_mag(gx, gy);
    chk("pix_we_seen", pix_we, 1);
    chk("pix_addr", pix_addr, 64'(idx));
    chk("pix_data", pix_data, 64'(m));
    chk("pix_edge", pix_edge, (m >= THRESH) ? 64'd1 : 64'd0);
    tick();
    chk("pix_we_pulse", pix_we, 0);
  endtask

  task automatic finish_frame();
    int n, d0;
    d0 = done_cnt;
    n = 0;
    while (!done && n < 10) begin tick(); n++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("done_count", 64'(done_cnt - d0), 1);
  endtask

  initial begin
    int w0, n, gxs[NPIX], gys[NPIX];

    // reset held 3 cycles with start pulses that must be ignored
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'(i % 2);
      tick();
    end
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_after_reset", all_outs(), 0);
    tick();
    chk("still_idle", {win_req, busy}, 0);

    // tiny frame with constant engine results
    w0 = we_cnt;
    do_start();
    for (int i = 0; i < NPIX; i++) pixel(100, -50, i);
    finish_frame();
    chk("frame1_writes", 64'(we_cnt - w0), 64'(NPIX));

    // saturation/sign corners followed by random results
    w0 = we_cnt;
    gxs[0] = -32768; gys[0] = 10;
    gxs[1] = 3;      gys[1] = -4;
    for (int i = 2; i < NPIX; i++) begin gxs[i] = rnd_res(); gys[i] = rnd_res(); end
    do_start();
    start = 1'b1;                  // start while busy is ignored
    for (int i = 0; i < NPIX; i++) begin
      pixel(gxs[i], gys[i], i);
      start = 1'b0;
    end
    finish_frame();
    chk("frame2_writes", 64'(we_cnt - w0), 64'(NPIX));

    // engine that never finishes -> abort after TIMEOUT cycles
    w0 = we_cnt;
    do_start();
    n = 0;
    while (!win_req && n < 10) begin tick(); n++; end
    tick();
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    n = 0;
    while (eng_en && n < 200) begin tick(); n++; end
    chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("timeout_done", done, 1);
    chk("timeout_error", error, 1);
    chk("timeout_eng_en", eng_en, 0);
    tick();
    chk("error_sticky", error, 1);
    chk("timeout_no_write", 64'(we_cnt - w0), 0);

    // restart clears error; reset after two writes
    do_start();
    pixel(rnd_res(), rnd_res(), 0);
    pixel(rnd_res(), rnd_res(), 1);
    w0 = we_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midframe_reset_outs", all_outs(), 0);
    repeat (20) tick();
    chk("no_write_after_reset", 64'(we_cnt - w0), 0);
    chk("idle_after_midreset", busy, 0);

    // full frame again from address 0
    w0 = we_cnt;
    do_start();
    for (int i = 0; i < NPIX; i++) pixel(rnd_res(), rnd_res(), i);
    finish_frame();
    chk("frame3_writes", 64'(we_cnt - w0), 64'(NPIX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
